// File: rtl/calc_key_entry_pkg.sv
// Shared key codes, FSM states and sizing for the calculator key-entry block.
// Optional backspace key: CALC_KEY_ENTRY_BACKSPACE_EN.
package calc_pkg;

  localparam int DEF_MAX_DIGITS = 4;

  localparam logic [7:0] KEY_ADD = 8'h61;
  localparam logic [7:0] KEY_SUB = 8'h62;
  localparam logic [7:0] KEY_MUL = 8'h63;
  localparam logic [7:0] KEY_DIV = 8'h64;
  localparam logic [7:0] KEY_EQ  = 8'h65;
  localparam logic [7:0] KEY_CLR = 8'h66;
  localparam logic [7:0] KEY_BS  = 8'h08;
  localparam logic [7:0] KEY_D0  = 8'h30;
  localparam logic [7:0] KEY_D9  = 8'h39;

  typedef enum logic [1:0] {
    S_NUM1,
    S_NUM2,
    S_DONE
  } state_t;

endpackage

// File: rtl/calc_key_entry_if.sv
// Key stream in, assembled expression out.
// master = key source / consumer, slave = calc_key_entry.
interface calc_key_entry_if
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = DEF_MAX_DIGITS,
  parameter int KEY_W      = 8
);

  localparam int NW = 4 * MAX_DIGITS;
  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic             key_valid;
  logic [KEY_W-1:0] key_code;
  logic [NW-1:0]    reg_num1;
  logic [NW-1:0]    reg_num2;
  logic [CW-1:0]    cnt1;
  logic [CW-1:0]    cnt2;
  logic [7:0]       sym;
  logic             calc_go;
  logic             key_err;

  modport master (
    output key_valid, key_code,
    input  reg_num1, reg_num2, cnt1, cnt2,
    input  sym, calc_go, key_err
  );

  modport slave (
    input  key_valid, key_code,
    output reg_num1, reg_num2, cnt1, cnt2,
    output sym, calc_go, key_err
  );

endinterface

// File: rtl/calc_key_entry_decode.sv
// Combinational key classifier: class flags plus BCD digit value.
// Backspace class only exists with CALC_KEY_ENTRY_BACKSPACE_EN.
module calc_key_decode
  import calc_pkg::*;
#(
  parameter int KEY_W = 8
) (
  input  logic [KEY_W-1:0] key_code,
  output logic             digit,
  output logic             op,
  output logic             eq,
  output logic             clr,
  output logic             bs,
  output logic [3:0]       value
);

  // Classify the key; unknown codes leave every flag low.
  always_comb begin
    digit = (key_code >= KEY_W'(KEY_D0))
         && (key_code <= KEY_W'(KEY_D9));
    op    = (key_code >= KEY_W'(KEY_ADD))
         && (key_code <= KEY_W'(KEY_DIV));
    eq    = (key_code == KEY_W'(KEY_EQ));
    clr   = (key_code == KEY_W'(KEY_CLR));
`ifdef CALC_KEY_ENTRY_BACKSPACE_EN
    bs    = (key_code == KEY_W'(KEY_BS));
`else
    bs    = 1'b0;
`endif
    value = key_code[3:0];
  end

endmodule

// File: rtl/calc_key_entry.sv
// Key-entry sequencer: builds two BCD operands and an operator.
// Backspace support: define CALC_KEY_ENTRY_BACKSPACE_EN.
module calc_key_entry
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = DEF_MAX_DIGITS,
  parameter int KEY_W      = 8
) (
  input  logic           clk,
  input  logic           rst,
  calc_key_entry_if.slave bus
);

  localparam int NW = 4 * MAX_DIGITS;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_DIGITS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic       dig;
  logic       op;
  logic       eq;
  logic       clr;
  logic       bs;
  logic [3:0] dval;
  state_t     state;

  calc_key_decode #(.KEY_W(KEY_W)) u_dec (
    .key_code (bus.key_code),
    .digit    (dig),
    .op       (op),
    .eq       (eq),
    .clr      (clr),
    .bs       (bs),
    .value    (dval)
  );

  // Entry FSM; operands, counts, sym and pulses are all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_NUM1;
      bus.reg_num1 <= '0;
      bus.reg_num2 <= '0;
      bus.cnt1     <= '0;
      bus.cnt2     <= '0;
      bus.sym      <= '0;
      bus.calc_go  <= 1'b0;
      bus.key_err  <= 1'b0;
    end else begin
      bus.calc_go <= 1'b0;
      bus.key_err <= 1'b0;
      if (bus.key_valid) begin
        unique case (1'b1)
          dig: begin
            unique case (state)
              S_NUM1: begin
                if (bus.cnt1 < CMAX) begin
                  bus.reg_num1 <=
                    {bus.reg_num1[NW-5:0], dval};
                  bus.cnt1 <= bus.cnt1 + ONE;
                end else begin
                  bus.key_err <= 1'b1;
                end
              end
              S_NUM2: begin
                if (bus.cnt2 < CMAX) begin
                  bus.reg_num2 <=
                    {bus.reg_num2[NW-5:0], dval};
                  bus.cnt2 <= bus.cnt2 + ONE;
                end else begin
                  bus.key_err <= 1'b1;
                end
              end
              default: begin
                // New expression starts from this digit.
                bus.reg_num1 <= NW'(dval);
                bus.reg_num2 <= '0;
                bus.cnt1     <= ONE;
                bus.cnt2     <= '0;
                bus.sym      <= '0;
                state        <= S_NUM1;
              end
            endcase
          end
          op: begin
            unique case (state)
              S_NUM1: begin
                if (bus.cnt1 != '0) begin
                  bus.sym <= bus.key_code[7:0];
                  state   <= S_NUM2;
                end else begin
                  bus.key_err <= 1'b1;
                end
              end
              S_NUM2: begin
                if (bus.cnt2 == '0) begin
                  bus.sym <= bus.key_code[7:0];
                end else begin
                  bus.key_err <= 1'b1;
                end
              end
              default: bus.key_err <= 1'b1;
            endcase
          end
          eq: begin
            if (state == S_NUM2 && bus.cnt2 != '0) begin
              state       <= S_DONE;
              bus.calc_go <= 1'b1;
            end else begin
              bus.key_err <= 1'b1;
            end
          end
          clr: begin
            state        <= S_NUM1;
            bus.reg_num1 <= '0;
            bus.reg_num2 <= '0;
            bus.cnt1     <= '0;
            bus.cnt2     <= '0;
            bus.sym      <= '0;
          end
          bs: begin
`ifdef CALC_KEY_ENTRY_BACKSPACE_EN
            unique case (state)
              S_NUM1: begin
                if (bus.cnt1 != '0) begin
                  bus.reg_num1 <=
                    {4'h0, bus.reg_num1[NW-1:4]};
                  bus.cnt1 <= bus.cnt1 - ONE;
                end else begin
                  bus.key_err <= 1'b1;
                end
              end
              S_NUM2: begin
                if (bus.cnt2 != '0) begin
                  bus.reg_num2 <=
                    {4'h0, bus.reg_num2[NW-1:4]};
                  bus.cnt2 <= bus.cnt2 - ONE;
                end else begin
                  // Backing over the operator reopens operand 1.
                  bus.sym <= '0;
                  state   <= S_NUM1;
                end
              end
              default: bus.key_err <= 1'b1;
            endcase
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_key_entry.sv
// Scoreboard bench for calc_key_entry: directed plan then random keys.
// Reference model keeps operands as digit queues.
module tb_calc_key_entry;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  calc_key_entry_if bus ();

  calc_key_entry dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          due;
    logic [15:0] n1;
    logic [15:0] n2;
    logic [2:0]  c1;
    logic [2:0]  c2;
    logic [7:0]  sym;
    logic        go;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int unsigned d1[$];
  int unsigned d2[$];
  int          phase;  // 0 first operand, 1 second, 2 done
  logic [7:0]  m_sym;

  function automatic logic [15:0] bcd(input int unsigned q[$]);
    logic [15:0] v;
    v = 16'h0;
    foreach (q[i]) v = (v << 4) | 16'(q[i]);
    return v;
  endfunction

  task automatic m_clear();
    d1 = {};
    d2 = {};
    m_sym = 8'h00;
    phase = 0;
  endtask

  task automatic m_step(input bit r, input bit kv,
                        input logic [7:0] k,
                        output bit go, output bit err);
    go = 0;
    err = 0;
    if (r) begin
      m_clear();
    end else if (kv) begin
      if (k >= "0" && k <= "9") begin
        if (phase == 0) begin
          if (d1.size() < 4) d1.push_back(int'(k) - 48);
          else err = 1;
        end else if (phase == 1) begin
          if (d2.size() < 4) d2.push_back(int'(k) - 48);
          else err = 1;
        end else begin
          m_clear();
          d1.push_back(int'(k) - 48);
        end
      end else if (k >= "a" && k <= "d") begin
        if (phase == 0 && d1.size() > 0) begin
          m_sym = k;
          phase = 1;
        end else if (phase == 1 && d2.size() == 0) begin
          m_sym = k;
        end else begin
          err = 1;
        end
      end else if (k == "e") begin
        if (phase == 1 && d2.size() > 0) begin
          phase = 2;
          go = 1;
        end else begin
          err = 1;
        end
      end else if (k == "f") begin
        m_clear();
      end
`ifdef CALC_KEY_ENTRY_BACKSPACE_EN
      else if (k == 8'h08) begin
        if (phase == 0) begin
          if (d1.size() > 0) void'(d1.pop_back());
          else err = 1;
        end else if (phase == 1) begin
          if (d2.size() > 0) void'(d2.pop_back());
          else begin
            phase = 0;
            m_sym = 8'h00;
          end
        end else begin
          err = 1;
        end
      end
`endif
    end
  endtask

  // Drive one cycle of input and queue the model's prediction.
  task automatic send(input bit r, input bit kv,
                      input logic [7:0] k);
    exp_t e;
    bit go, err;
    @(posedge clk);
    #1;
    rst = r;
    bus.key_valid = kv;
    bus.key_code = k;
    m_step(r, kv, k, go, err);
    e.due = cyc + 1;
    e.n1 = bcd(d1);
    e.n2 = bcd(d2);
    e.c1 = 3'(d1.size());
    e.c2 = 3'(d2.size());
    e.sym = m_sym;
    e.go = go;
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic key(input logic [7:0] k);
    send(1'b0, 1'b1, k);
  endtask

  // Idle cycle whose expected outputs are given explicitly.
  task automatic hold(input logic [15:0] n1,
                      input logic [15:0] n2,
                      input logic [2:0] c1,
                      input logic [2:0] c2,
                      input logic [7:0] s);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code = 8'h00;
    e.due = cyc + 1;
    e.n1 = n1;
    e.n2 = n2;
    e.c1 = c1;
    e.c2 = c2;
    e.sym = s;
    e.go = 1'b0;
    e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h",
               nm, cyc, act, req);
    end
  endtask

  // Monitor: compare every prediction in the cycle it falls due.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      chk("stale_expect", 32'(cyc), 32'(e.due));
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("reg_num1", 32'(bus.reg_num1), 32'(e.n1));
      chk("reg_num2", 32'(bus.reg_num2), 32'(e.n2));
      chk("cnt1", 32'(bus.cnt1), 32'(e.c1));
      chk("cnt2", 32'(bus.cnt2), 32'(e.c2));
      chk("sym", 32'(bus.sym), 32'(e.sym));
      chk("calc_go", 32'(bus.calc_go), 32'(e.go));
      chk("key_err", 32'(bus.key_err), 32'(e.err));
    end
  end

  initial begin
    logic [7:0] k;
    int r;
    bus.key_valid = 1'b0;
    bus.key_code = 8'h00;
    m_clear();
    send(1'b1, 1'b0, 8'h00);
    send(1'b1, 1'b0, 8'h00);
    hold(16'h0, 16'h0, 3'd0, 3'd0, 8'h00);

    // Plan 1
    key("1"); key("2"); key("a");
    key("3"); key("4"); key("e");
    hold(16'h0012, 16'h0034, 3'd2, 3'd2, 8'h61);
    // Plan 2
    key("f");
    key("9"); key("8"); key("7"); key("6"); key("5");
    hold(16'h9876, 16'h0, 3'd4, 3'd0, 8'h00);
    // Plan 3
    key("f");
    key("a"); key("5"); key("e");
    hold(16'h0005, 16'h0, 3'd1, 3'd0, 8'h00);
    // Plan 4
    key("f");
    key("7"); key("a"); key("c"); key("2"); key("e");
    hold(16'h0007, 16'h0002, 3'd1, 3'd1, 8'h63);
    key("4");
    hold(16'h0004, 16'h0, 3'd1, 3'd0, 8'h00);
    // Plan 5
    key("f");
    key("3"); key("b"); key("1");
    send(1'b1, 1'b1, "e");
    hold(16'h0, 16'h0, 3'd0, 3'd0, 8'h00);
    // Plan 6
    key("1"); key("2"); key(8'h08); key("a"); key(8'h08);
`ifdef CALC_KEY_ENTRY_BACKSPACE_EN
    hold(16'h0001, 16'h0, 3'd1, 3'd0, 8'h00);
    key("5");
    hold(16'h0015, 16'h0, 3'd2, 3'd0, 8'h00);
`else
    hold(16'h0012, 16'h0, 3'd2, 3'd0, 8'h61);
`endif

    // Random keys, with occasional idles and resets
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45) k = 8'(8'h30 + $urandom_range(0, 9));
      else if (r < 58) k = 8'(8'h61 + $urandom_range(0, 3));
      else if (r < 70) k = 8'h65;
      else if (r < 74) k = 8'h66;
      else if (r < 82) k = 8'h08;
      else k = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 59) == 0)
        send(1'b1, 1'b1, k);
      else if ($urandom_range(0, 9) == 0)
        send(1'b0, 1'b0, k);
      else
        send(1'b0, 1'b1, k);
    end
    send(1'b0, 1'b0, 8'h00);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0",
               exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
